// File: rtl/serial_tx_if.sv
// Handshake and serial-link bundle for serial_tx_shifter.
// The producer/bench uses the master modport and the shifter uses the slave modport.
interface serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             load_valid;
  logic             load_ready;
  logic             dir;
  logic             hold;
  logic             ser_out;
  logic             ser_en;
  logic             busy;
  logic             done;

  modport master (
    output data, load_valid, dir, hold,
    input  load_ready, ser_out, ser_en, busy, done
  );

  modport slave (
    input  data, load_valid, dir, hold,
    output load_ready, ser_out, ser_en, busy, done
  );
endinterface

// File: rtl/serial_tx_shifter.sv
// Parallel-in, serial-out transmitter: accepts a word on a valid/ready handshake and sends it one bit per cycle.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_tx_shifter #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  serial_tx_if.slave  tx
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef SERIAL_TX_PARITY_EN
    ST_DONE   = 2'd2,
    ST_PARITY = 2'd3
`else
    ST_DONE   = 2'd2
`endif
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] sreg_r;
  logic [CW-1:0]    cnt_r;
  logic             dir_r;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_r;
`endif

  logic load_ready_s;
  logic ser_out_s;
  logic ser_en_s;
  logic busy_s;
  logic done_s;
  logic accept_s;
  logic shift_s;

  // The handshake is refused while reset is asserted, even though the state already reads IDLE.
  assign load_ready_s = (state_r == ST_IDLE) && !rst;
  assign accept_s     = tx.load_valid && load_ready_s;
  assign shift_s      = (state_r == ST_SHIFT) && !tx.hold;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_s   = state_r;
    ser_out_s = 1'b0;
    ser_en_s  = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        busy_s    = 1'b1;
        ser_en_s  = !tx.hold;
        ser_out_s = dir_r ? sreg_r[0] : sreg_r[WIDTH-1];
        if (shift_s && (cnt_r == CW'(WIDTH - 1))) begin
`ifdef SERIAL_TX_PARITY_EN
          state_s = ST_PARITY;
`else
          state_s = ST_DONE;
`endif
        end else begin
          state_s = ST_SHIFT;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        busy_s    = 1'b1;
        ser_en_s  = !tx.hold;
        ser_out_s = par_r;
        if (!tx.hold) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_PARITY;
        end
      end
`endif
      ST_DONE: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Word capture on handshake, then zero-filled shifting on every un-held SHIFT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_r <= '0;
      cnt_r  <= '0;
      dir_r  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_r  <= 1'b0;
`endif
    end else if (accept_s) begin
      sreg_r <= tx.data;
      cnt_r  <= '0;
      dir_r  <= tx.dir;
`ifdef SERIAL_TX_PARITY_EN
      par_r  <= ^tx.data;
`endif
    end else if (shift_s) begin
      sreg_r <= dir_r ? {1'b0, sreg_r[WIDTH-1:1]} : {sreg_r[WIDTH-2:0], 1'b0};
      cnt_r  <= cnt_r + CW'(1);
    end else begin
      sreg_r <= sreg_r;
      cnt_r  <= cnt_r;
    end
  end

  assign tx.load_ready = load_ready_s;
  assign tx.ser_out    = ser_out_s;
  assign tx.ser_en     = ser_en_s;
  assign tx.busy       = busy_s;
  assign tx.done       = done_s;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed, table-driven bench for serial_tx_shifter (WIDTH=8), covering both the plain and the
// SERIAL_TX_PARITY_EN builds.
module tb_serial_tx_shifter;
  localparam int W = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_tx_if #(.WIDTH(W)) tx ();
  serial_tx_shifter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .tx(tx));

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs  = 0;

  // exp_seq holds the data bits in transmission order, first bit at the MSB.
  typedef struct {
    logic [7:0] data;
    logic       dir;
    int         hold_at;
    int         hold_len;
    logic [7:0] exp_seq;
    logic       exp_par;
  } vec_t;

  vec_t vecs [7];

  // Handshakes are counted at the falling edge, half a cycle before the edge that takes them.
  always @(negedge clk) begin
    if (!rst && tx.load_valid && tx.load_ready) n_hs++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Call this #1 after a rising edge; it returns #1 after the rising edge that ends the done cycle.
  task automatic send(input vec_t v, input bit keep_valid);
    logic [8:0] got;
    logic [8:0] exp;
    logic       nxt;
    int         nbits;
    int         done_k;
    tx.data       = v.data;
    tx.dir        = v.dir;
    tx.hold       = 1'b0;
    tx.load_valid = 1'b1;
    #1;
    check("ready_idle", 32'(tx.load_ready), 32'd1);
    check("busy_idle", 32'(tx.busy), 32'd0);
    check("done_idle", 32'(tx.done), 32'd0);
    @(posedge clk);
    #1;
    if (!keep_valid) tx.load_valid = 1'b0;
    got    = '0;
    nbits  = 0;
    done_k = 0;
    for (int k = 1; k <= 40 && done_k == 0; k++) begin
      tx.hold = (k >= v.hold_at) && (k < v.hold_at + v.hold_len);
      if (keep_valid) begin
        tx.data = v.data ^ 8'(k * 29);
        tx.dir  = ~tx.dir;
      end
      @(negedge clk);
      if (k == 1) check("busy_frame", 32'(tx.busy), 32'd1);
      if (tx.hold) begin
        nxt = (nbits < 8) ? v.exp_seq[7 - nbits] : v.exp_par;
        check("hold_en", 32'(tx.ser_en), 32'd0);
        check("hold_out", 32'(tx.ser_out), 32'(nxt));
      end
      if (tx.ser_en) begin
        got   = {got[7:0], tx.ser_out};
        nbits = nbits + 1;
      end
      if (tx.done) done_k = k;
      if (done_k == 0) begin
        @(posedge clk);
        #1;
      end
    end
    exp = (PB == 1) ? {v.exp_seq, v.exp_par} : {1'b0, v.exp_seq};
    check("done_seen", 32'(done_k != 0), 32'd1);
    check("bit_count", 32'(nbits), 32'(8 + PB));
    check("bit_seq", 32'(got), 32'(exp));
    check("done_cycle", 32'(done_k), 32'(9 + v.hold_len + PB));
    @(posedge clk);
    #1;
    tx.hold = 1'b0;
    check("done_pulse_end", 32'(tx.done), 32'd0);
    check("ready_after", 32'(tx.load_ready), 32'd1);
  endtask

  initial begin
    int hs0;
    int dn;
    vecs[0] = '{8'hB4, 1'b1, 0, 0, 8'b0010_1101, 1'b0};
    vecs[1] = '{8'hB4, 1'b0, 0, 0, 8'b1011_0100, 1'b0};
    vecs[2] = '{8'hB4, 1'b0, 3, 3, 8'b1011_0100, 1'b0};
    vecs[3] = '{8'h0F, 1'b1, 0, 0, 8'b1111_0000, 1'b0};
    vecs[4] = '{8'h07, 1'b1, 0, 0, 8'b1110_0000, 1'b1};
    vecs[5] = '{8'h81, 1'b0, 8, 2, 8'b1000_0001, 1'b0};
    vecs[6] = '{8'h3C, 1'b0, 0, 0, 8'b0011_1100, 1'b0};

    rst           = 1'b1;
    tx.data       = 8'h00;
    tx.dir        = 1'b0;
    tx.hold       = 1'b0;
    tx.load_valid = 1'b0;
    #3;
    check("rst_ready", 32'(tx.load_ready), 32'd0);
    check("rst_busy", 32'(tx.busy), 32'd0);
    check("rst_en", 32'(tx.ser_en), 32'd0);
    check("rst_out", 32'(tx.ser_out), 32'd0);
    check("rst_done", 32'(tx.done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_post_rst", 32'(tx.load_ready), 32'd1);

    for (int i = 0; i < 7; i++) send(vecs[i], 1'b0);

    // Reset mid-frame after four bits, asserted between clock edges.
    tx.data       = 8'hB4;
    tx.dir        = 1'b1;
    tx.load_valid = 1'b1;
    @(posedge clk);
    #1;
    tx.load_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("busy_before_rst", 32'(tx.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(tx.busy), 32'd0);
    check("arst_en", 32'(tx.ser_en), 32'd0);
    check("arst_out", 32'(tx.ser_out), 32'd0);
    check("arst_ready", 32'(tx.load_ready), 32'd0);
    check("arst_done", 32'(tx.done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("arst_ready_rel", 32'(tx.load_ready), 32'd1);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx.done) dn++;
    end
    check("arst_no_done", 32'(dn), 32'd0);
    @(posedge clk);
    #1;
    send(vecs[3], 1'b0);

    // load_valid held high with changing data: only the words presented in IDLE are taken.
    hs0 = n_hs;
    send(vecs[0], 1'b1);
    send(vecs[6], 1'b0);
    repeat (3) @(posedge clk);
    check("handshakes", 32'(n_hs - hs0), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion well before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
